// File: rtl/condlogic_mb_if.sv
// Decoder-to-condition-unit bundle: raw decoder enables and flag traffic in,
// gated enables, stall and debug flags out.
interface condlogic_mb_if #(
  parameter int NBANK = 4
) ();
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

  logic          Valid;
  logic [3:0]    Cond;
  logic [BW-1:0] FlagSel;
  logic [3:0]    ALUFlags;
  logic          FlagsW;
  logic [BW-1:0] FlagWSel;
  logic          RegW;
  logic          MemW;
  logic          PCS;
  logic          CondEx;
  logic          PCSrc;
  logic          RegWrite;
  logic          MemWrite;
  logic          Stall;
  logic [3:0]    FlagsOut;

  modport master (
    output Valid, Cond, FlagSel, ALUFlags, FlagsW, FlagWSel, RegW, MemW, PCS,
    input  CondEx, PCSrc, RegWrite, MemWrite, Stall, FlagsOut
  );

  modport slave (
    input  Valid, Cond, FlagSel, ALUFlags, FlagsW, FlagWSel, RegW, MemW, PCS,
    output CondEx, PCSrc, RegWrite, MemWrite, Stall, FlagsOut
  );
endinterface

// File: rtl/condlogic_mb.sv
// Multi-bank NZCV condition unit: evaluates condition codes, gates enables and
// commits flag writes through a WLAT-deep delay line with forwarding or stalling.
module condlogic_mb #(
  parameter int NBANK     = 4,
  parameter int WLAT      = 2,
  parameter int FWD       = 1,
  parameter int PREDICATE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  condlogic_mb_if.slave bus
);
  localparam int BW  = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int NST = (WLAT > 0) ? WLAT : 1;

  logic [3:0]    bank [NBANK];
  logic          st_v [NST];
  logic [BW-1:0] st_b [NST];
  logic [3:0]    st_f [NST];

  logic       act;
  logic       always_code;
  logic       pending;
  logic       stall;
  logic       cond_ex;
  logic       gate;
  logic       issue;
  logic [3:0] fwd_flags;
  logic [3:0] committed;
  logic [3:0] eval_flags;

  function automatic logic cond_pass(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'b0000: cond_pass = z;
      4'b1000: cond_pass = ~z;
      4'b0001: cond_pass = v;
      4'b1001: cond_pass = ~v;
      4'b0010: cond_pass = ~z & (n == v);
      4'b1010: cond_pass = z | (n != v);
      4'b0011: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b0100: cond_pass = ~(c | z);
      4'b1100: cond_pass = c | z;
      4'b0101: cond_pass = ~c;
      4'b1101: cond_pass = c;
      4'b0110: cond_pass = n;
      4'b1110: cond_pass = ~n;
      default: cond_pass = 1'b1;
    endcase
  endfunction

  // Stage 0 is the youngest entry, so scanning downwards leaves the youngest match.
  always_comb begin
    pending   = 1'b0;
    fwd_flags = 4'b0000;
    committed = 4'b0000;
    for (int i = NST - 1; i >= 0; i--) begin
      if (st_v[i] && (st_b[i] == bus.FlagSel)) begin
        pending   = 1'b1;
        fwd_flags = st_f[i];
      end
    end
    for (int b = 0; b < NBANK; b++) begin
      if (bus.FlagSel == BW'(b)) committed = bank[b];
    end
    act         = bus.Valid & rst_n;
    always_code = (bus.Cond[2:0] == 3'b111);
    eval_flags  = ((FWD != 0) && pending) ? fwd_flags : committed;
    stall       = act & (FWD == 0) & pending & ~always_code;
    cond_ex     = act & ~stall & cond_pass(bus.Cond, eval_flags);
    gate        = (PREDICATE != 0) ? cond_ex : (act & ~stall);
    issue       = act & ~stall & bus.FlagsW & ((PREDICATE != 0) ? cond_ex : 1'b1);
  end

  assign bus.CondEx   = cond_ex;
  assign bus.Stall    = stall;
  assign bus.PCSrc    = bus.PCS & cond_ex;
  assign bus.RegWrite = bus.RegW & gate;
  assign bus.MemWrite = bus.MemW & gate;
  assign bus.FlagsOut = committed;

  // The delay line shifts every cycle regardless of stall; reset drops in-flight writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < NBANK; b++) bank[b] <= 4'b0000;
      for (int i = 0; i < NST; i++) begin
        st_v[i] <= 1'b0;
        st_b[i] <= '0;
        st_f[i] <= 4'b0000;
      end
    end else if (WLAT == 0) begin
      for (int b = 0; b < NBANK; b++) begin
        if (issue && (bus.FlagWSel == BW'(b))) bank[b] <= bus.ALUFlags;
      end
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (st_v[NST-1] && (st_b[NST-1] == BW'(b))) bank[b] <= st_f[NST-1];
      end
      st_v[0] <= issue;
      st_b[0] <= bus.FlagWSel;
      st_f[0] <= bus.ALUFlags;
      for (int i = 1; i < NST; i++) begin
        st_v[i] <= st_v[i-1];
        st_b[i] <= st_b[i-1];
        st_f[i] <= st_f[i-1];
      end
    end
  end
endmodule

// File: tb/tb_condlogic_mb.sv
// Drives four differently-configured condlogic_mb instances with shared stimulus
// and compares them against a write-list reference model.
module tb_condlogic_mb;
  localparam int NDUT = 4;

  function automatic int wl_of(input int d);
    case (d)
      0:       return 0;
      3:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int fw_of(input int d);
    return (d == 0 || d == 2) ? 1 : 0;
  endfunction

  function automatic int pr_of(input int d);
    return (d == 3) ? 0 : 1;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [3:0] cond;
  logic [1:0] flag_sel;
  logic [3:0] alu_flags;
  logic       flags_w;
  logic [1:0] flag_w_sel;
  logic       reg_w;
  logic       mem_w;
  logic       pcs;

  logic       dut_cond_ex   [NDUT];
  logic       dut_pc_src    [NDUT];
  logic       dut_reg_write [NDUT];
  logic       dut_mem_write [NDUT];
  logic       dut_stall     [NDUT];
  logic [3:0] dut_flags     [NDUT];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference state: committed banks plus a list of issued-but-uncommitted writes.
  logic [3:0] m_bank [NDUT][4];
  bit         e_v    [NDUT][8];
  int         e_t    [NDUT][8];
  int         e_b    [NDUT][8];
  logic [3:0] e_f    [NDUT][8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    condlogic_mb_if #(.NBANK(4)) bus ();
    assign bus.Valid    = valid;
    assign bus.Cond     = cond;
    assign bus.FlagSel  = flag_sel;
    assign bus.ALUFlags = alu_flags;
    assign bus.FlagsW   = flags_w;
    assign bus.FlagWSel = flag_w_sel;
    assign bus.RegW     = reg_w;
    assign bus.MemW     = mem_w;
    assign bus.PCS      = pcs;
    condlogic_mb #(
      .NBANK(4), .WLAT(wl_of(g)), .FWD(fw_of(g)), .PREDICATE(pr_of(g))
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
    assign dut_cond_ex[g]   = bus.CondEx;
    assign dut_pc_src[g]    = bus.PCSrc;
    assign dut_reg_write[g] = bus.RegWrite;
    assign dut_mem_write[g] = bus.MemWrite;
    assign dut_stall[g]     = bus.Stall;
    assign dut_flags[g]     = bus.FlagsOut;
  end

  task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Codes with bit 3 set are the complement of the same low bits, except "always".
  function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (code[2:0])
      3'd0:    base = z;
      3'd1:    base = v;
      3'd2:    base = !z && (n == v);
      3'd3:    base = (n == v);
      3'd4:    base = !(c || z);
      3'd5:    base = !c;
      3'd6:    base = n;
      default: return 1'b1;
    endcase
    return code[3] ? !base : base;
  endfunction

  task automatic model_eval(input int d, output logic ex, output logic pc, output logic rw,
                            output logic mw, output logic st, output logic iss);
    logic act, pend, always_c, gate;
    logic [3:0] f;
    int best_t;
    act      = valid && rst_n;
    always_c = (cond[2:0] == 3'b111);
    pend     = 1'b0;
    best_t   = -1;
    f        = m_bank[d][flag_sel];
    for (int s = 0; s < 8; s++) begin
      if (e_v[d][s] && e_b[d][s] == int'(flag_sel)) begin
        pend = 1'b1;
        if (fw_of(d) == 1 && e_t[d][s] > best_t) begin
          best_t = e_t[d][s];
          f      = e_f[d][s];
        end
      end
    end
    st   = act && fw_of(d) == 0 && pend && !always_c;
    ex   = act && !st && ref_cond(cond, f);
    pc   = pcs && ex;
    gate = (pr_of(d) == 1) ? ex : (act && !st);
    rw   = reg_w && gate;
    mw   = mem_w && gate;
    iss  = act && !st && flags_w && (pr_of(d) == 0 || ex);
  endtask

  // A write issued in cycle t becomes committed at the edge closing cycle t+WLAT.
  task automatic model_update(input int d, input logic iss);
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) m_bank[d][b] = 4'b0000;
      for (int s = 0; s < 8; s++) e_v[d][s] = 1'b0;
      return;
    end
    for (int s = 0; s < 8; s++) begin
      if (e_v[d][s] && e_t[d][s] + wl_of(d) == cyc) begin
        m_bank[d][e_b[d][s]] = e_f[d][s];
        e_v[d][s] = 1'b0;
      end
    end
    if (iss) begin
      if (wl_of(d) == 0) begin
        m_bank[d][flag_w_sel] = alu_flags;
      end else begin
        for (int s = 0; s < 8; s++) begin
          if (!e_v[d][s]) begin
            e_v[d][s] = 1'b1;
            e_t[d][s] = cyc;
            e_b[d][s] = int'(flag_w_sel);
            e_f[d][s] = alu_flags;
            break;
          end
        end
      end
    end
  endtask

  task automatic run_cycle();
    logic ex, pc, rw, mw, st, iss;
    logic iss_v [NDUT];
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      model_eval(d, ex, pc, rw, mw, st, iss);
      iss_v[d] = iss;
      checkOutput($sformatf("dut%0d stall", d),     4'(dut_stall[d]),     4'(st));
      checkOutput($sformatf("dut%0d cond_ex", d),   4'(dut_cond_ex[d]),   4'(ex));
      checkOutput($sformatf("dut%0d pc_src", d),    4'(dut_pc_src[d]),    4'(pc));
      checkOutput($sformatf("dut%0d reg_write", d), 4'(dut_reg_write[d]), 4'(rw));
      checkOutput($sformatf("dut%0d mem_write", d), 4'(dut_mem_write[d]), 4'(mw));
      checkOutput($sformatf("dut%0d flags_out", d), dut_flags[d],         m_bank[d][flag_sel]);
    end
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) model_update(d, iss_v[d]);
    cyc++;
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [1:0] fs,
                               input logic [3:0] alu, input logic fw, input logic [1:0] fws,
                               input logic rw, input logic mw, input logic p);
    valid      = v;
    cond       = c;
    flag_sel   = fs;
    alu_flags  = alu;
    flags_w    = fw;
    flag_w_sel = fws;
    reg_w      = rw;
    mem_w      = mw;
    pcs        = p;
  endtask

  task automatic idle(input int n, input logic [1:0] fs);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 4'b0000, fs, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      run_cycle();
    end
  endtask

  initial begin
    logic [1:0] fs;
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      for (int b = 0; b < 4; b++) m_bank[d][b] = 4'b0000;
      for (int s = 0; s < 8; s++) e_v[d][s] = 1'b0;
    end
    checkOutput("reset flags_out", dut_flags[3], 4'b0000);
    checkOutput("reset stall", 4'(dut_stall[1]), 4'd0);
    idle(1, 2'd0);
    rst_n = 1'b1;

    // Single-cycle commit with forwarding: bank 2 written, then read.
    applyStimulus(1'b1, 4'b0111, 2'd0, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    run_cycle();
    applyStimulus(1'b1, 4'b0000, 2'd2, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    #2;
    checkOutput("wlat0 eq pc_src", 4'(dut_pc_src[0]), 4'd1);
    run_cycle();
    applyStimulus(1'b1, 4'b0000, 2'd1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    #2;
    checkOutput("wlat0 other bank cond_ex", 4'(dut_cond_ex[0]), 4'd0);
    run_cycle();
    idle(5, 2'd0);

    // Dependent LT branch behind a latency-2 write without forwarding.
    applyStimulus(1'b1, 4'b0111, 2'd0, 4'b1001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    run_cycle();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 4'b1011, 2'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      #2;
      checkOutput($sformatf("nofwd stall c%0d", k), 4'(dut_stall[1]), (k < 3) ? 4'd1 : 4'd0);
      if (k == 3) checkOutput("nofwd lt cond_ex", 4'(dut_cond_ex[1]), 4'd0);
      run_cycle();
    end
    idle(5, 2'd0);

    // Back-to-back writes to bank 3: youngest must be forwarded.
    applyStimulus(1'b1, 4'b0111, 2'd3, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    run_cycle();
    applyStimulus(1'b1, 4'b0111, 2'd3, 4'b0100, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    run_cycle();
    applyStimulus(1'b1, 4'b0000, 2'd3, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("fwd youngest cond_ex", 4'(dut_cond_ex[2]), 4'd1);
    checkOutput("fwd no stall", 4'(dut_stall[2]), 4'd0);
    run_cycle();
    idle(1, 2'd3);
    applyStimulus(1'b0, 4'b0000, 2'd3, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("fwd commit flags_out", dut_flags[2], 4'b0100);
    run_cycle();
    idle(4, 2'd0);

    // Predication: NE with z=1 suppresses writes only when PREDICATE=1.
    rst_n = 1'b0;
    idle(2, 2'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0111, 2'd0, 4'b0100, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    run_cycle();
    idle(4, 2'd0);
    applyStimulus(1'b1, 4'b1000, 2'd0, 4'b1010, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    #2;
    checkOutput("pred1 reg_write", 4'(dut_reg_write[2]), 4'd0);
    checkOutput("pred1 mem_write", 4'(dut_mem_write[2]), 4'd0);
    checkOutput("pred0 reg_write", 4'(dut_reg_write[3]), 4'd1);
    checkOutput("pred0 mem_write", 4'(dut_mem_write[3]), 4'd1);
    run_cycle();
    idle(4, 2'd1);
    applyStimulus(1'b0, 4'b0000, 2'd1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("pred1 bank unchanged", dut_flags[2], 4'b0000);
    checkOutput("pred0 bank written", dut_flags[3], 4'b1010);
    run_cycle();

    // Reset while a latency-3 write is in flight discards it.
    rst_n = 1'b0;
    idle(2, 2'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0111, 2'd0, 4'b1111, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    run_cycle();
    rst_n = 1'b0;
    idle(1, 2'd1);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0000, 2'd1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rst flight stall", 4'(dut_stall[3]), 4'd0);
    run_cycle();
    idle(4, 2'd1);
    applyStimulus(1'b1, 4'b0000, 2'd1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rst flight bank", dut_flags[3], 4'b0000);
    run_cycle();

    // Every condition code against every flag value on the zero-latency unit.
    for (int f = 0; f < 16; f++) begin
      applyStimulus(1'b1, 4'b1111, 2'd0, 4'(f), 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      run_cycle();
      for (int c = 0; c < 16; c++) begin
        applyStimulus(1'b1, 4'(c), 2'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput($sformatf("exh c%0d f%0d", c, f), 4'(dut_cond_ex[0]), 4'(ref_cond(4'(c), 4'(f))));
        run_cycle();
      end
    end

    // Random traffic, biased so writes often hit the bank being read.
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      fs    = 2'($urandom);
      applyStimulus($urandom_range(0, 9) != 0, 4'($urandom), fs, 4'($urandom),
                    1'($urandom), ($urandom_range(0, 1) == 1) ? fs : 2'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/condlogic_mb.md
# condlogic_mb

Multi-bank, latency-aware successor to the single-flag-register condition unit. It evaluates a 4-bit condition code against one of `NBANK` NZCV flag banks and gates branch, register-write and memory-write enables. Flag writes commit through a parametrised delay line, with scoreboarding and optional forwarding. It sits in the decode/execute boundary of the core, between the decoder's control outputs and the PC mux / register file / data-memory write enables.

## Interface
Parameters:
- `NBANK`, 4: number of flag banks, ≥1; `BW = (NBANK>1) ? $clog2(NBANK) : 1`.
- `WLAT`, 2: flag commit latency in cycles, 0..4.
- `FWD`, 1: 1 forwards in-flight flags to readers; 0 stalls readers instead.
- `PREDICATE`, 1: 1 gates RegWrite/MemWrite/flag issue by CondEx; 0 gates only PCSrc.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `Valid` in 1: instruction present this cycle.
- `Cond` in 4: condition code.
- `FlagSel` in BW: bank read for evaluation.
- `ALUFlags` in 4: {N,Z,C,V} produced by this instruction.
- `FlagsW` in 1: this instruction writes flags.
- `FlagWSel` in BW: bank written.
- `RegW`, `MemW`, `PCS` in 1 each: raw decoder enables.
- `CondEx` out 1: condition passed.
- `PCSrc`, `RegWrite`, `MemWrite` out 1 each: gated enables.
- `Stall` out 1: hold upstream; the same instruction is re-presented.
- `FlagsOut` out 4: committed flags of bank `FlagSel`, for debug.

## Operation
- Condition codes, evaluated on flags F = {n,z,c,v}:
  - 0000 z; 1000 ~z; 0001 v; 1001 ~v.
  - 0010 GT ~z&(n==v); 1010 LE z|(n!=v).
  - 0011 GE n==v; 1011 LT n!=v.
  - 0100 HI ~(c|z); 1100 LS c|z.
  - 0101 ~c; 1101 c; 0110 n; 1110 ~n.
  - 0111 and 1111 always true; these "always" codes need no flags.
- Flag source F for the current instruction:
  - If FWD=1 and bank `FlagSel` has in-flight writes: the youngest in-flight entry for that bank.
  - Otherwise: the committed bank register.
- `pending` = some in-flight entry targets `FlagSel`.
- `Stall` = Valid & ~FWD & pending & Cond not an always code.
- `CondEx` = Valid & ~Stall & cond(F).
- Enable gating:
  - `PCSrc` = PCS & CondEx.
  - `RegWrite` = RegW & (PREDICATE ? CondEx : Valid&~Stall); `MemWrite` is gated the same way.
- Flag write issue: `issue` = Valid & ~Stall & FlagsW & (PREDICATE ? CondEx : 1).
- Delay line:
  - WLAT=0: an issue writes bank FlagWSel at the same edge; nothing is ever in flight.
  - WLAT≥1: an issued entry {bank, flags} enters stage 1 and advances one stage per cycle unconditionally, including while stalled.
  - An entry leaving stage WLAT writes its bank.
  - At most one issue per cycle, so at most one commit per edge; in-order commit guarantees the youngest write wins.
- Reset (rst_n=0 at an edge): all banks = 4'b0000 and all stage valid bits = 0. In-flight writes are discarded, not committed.

## Timing
- All outputs are combinational from inputs plus state; there is no output register.
- Write issued in cycle t:
  - Committed value is visible from cycle t+WLAT+1.
  - Readers in cycles t+1..t+WLAT see the forwarded value (FWD=1), or Stall=1 (FWD=0, non-always code).
- FWD=0 stall length for an immediately dependent reader: exactly WLAT cycles.
- Reset values, with rst_n low or Valid=0: CondEx, PCSrc, RegWrite, MemWrite, Stall all 0. FlagsOut = 0 after reset.
- Simultaneous commit and read of the same bank in cycle t+WLAT+1: the reader sees the committed value; no stall.
- Writes to a bank other than FlagSel never cause a stall.

## Test plan
- Reset then WLAT=0, FWD=1, NBANK=4:
  - Issue FlagsW, bank 2, ALUFlags=0100; next cycle Cond=0000, FlagSel=2, PCS=1 -> PCSrc=1.
  - Same read with FlagSel=1 -> CondEx=0.
- WLAT=2, FWD=0, dependent branch:
  - Write bank 0 = 1001 in cycle 0; Cond=1011 (LT), FlagSel=0 in cycle 1 -> Stall=1 in cycles 1–2; cycle 3: Stall=0, CondEx=0 (n==v).
- WLAT=2, FWD=1, back-to-back writes:
  - Bank 3 = 0000 in cycle 0, then bank 3 = 0100 in cycle 1; Cond=0000 in cycle 2 -> CondEx=1 (youngest forwarded), no stall.
  - FlagsOut for bank 3 = 0100 from cycle 4.
- PREDICATE=1:
  - Cond=1000 with z=1, FlagsW=1, RegW=1, MemW=1 -> RegWrite=0, MemWrite=0, no issue (bank unchanged).
  - With PREDICATE=0 -> RegWrite=1, MemWrite=1, flags issued.
- Reset mid-flight:
  - WLAT=3, write bank 1 = 1111, assert rst_n=0 one cycle later -> bank 1 stays 0000.
  - Stall=0 afterwards for FlagSel=1 with FWD=0.
- Exhaustive: all 16 codes × 16 flag values, WLAT=0 -> CondEx matches the code list above; codes 0111 and 1111 are always 1.
